pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with a valid/ready handshake
// and a 2-entry skid buffer. Payload passes through with 1-cycle latency.
// Supports synchronous flush and presents NOP_VALUE whenever no entry is valid.
//
// Optional feature macro: PIPE_STAGE_PERF_CNT_EN (adds saturating bubble/stall counters).
//
// Ports:
//   clk           clock, all state updates on rising edge
//   rst           asynchronous active-low reset
//   flush_i       synchronous flush, discards all held entries
//   in_valid_i    upstream entry valid
//   in_ready_o    stage can accept an entry this cycle
//   in_data_i     upstream payload
//   out_valid_o   downstream entry valid
//   out_ready_i   downstream accepts entry this cycle
//   out_data_o    downstream payload (NOP_VALUE while out_valid_o=0)
//   occupancy_o   number of held entries (0..2)
//   bubble_cnt_o  [macro] cycles with out_valid_o=0 and out_ready_i=1
//   stall_cnt_o   [macro] cycles with in_valid_i=1 and in_ready_o=0

module pipe_stage_reg #(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    // Handshake outputs depend only on registered state, so out_ready_i never
    // reaches in_ready_o combinationally.
    assign in_ready_o  = (state_q != StTwo);
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = main_q;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_comb begin
        occupancy_o = 2'd0;
        case (state_q)
            StOne:   occupancy_o = 2'd1;
            StTwo:   occupancy_o = 2'd2;
            default: occupancy_o = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else if (flush_i) begin
            // A same-cycle in_fire is swallowed here; a same-cycle out_fire has
            // already been taken by downstream.
            state_q <= StEmpty;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_q <= StOne;
                        main_q  <= in_data_i;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data_i;
                    end else if (in_fire) begin
                        state_q <= StTwo;
                        skid_q  <= in_data_i;
                    end else if (out_fire) begin
                        state_q <= StEmpty;
                        main_q  <= NOP_VALUE;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        state_q <= StOne;
                        main_q  <= skid_q;
                        skid_q  <= NOP_VALUE;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    main_q  <= NOP_VALUE;
                    skid_q  <= NOP_VALUE;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Counters saturate at all-ones; flush does not clear them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (!out_valid_o && out_ready_i && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + CntOne;
            end
            if (in_valid_i && !in_ready_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg. Uses a non-zero NOP_VALUE so bubbles
// are distinguishable from zero payloads. Perf-counter tests build only when
// PIPE_STAGE_PERF_CNT_EN is defined.

module tb_pipe_stage_reg;

    localparam int unsigned       DW  = 32;
    localparam logic [DW-1:0]     NOP = 32'h0000_0013;

    logic          clk;
    logic          rst;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [1:0]    occupancy_o;

    int tests_run;
    int tests_failed;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0]   bubble_cnt_o;
    logic [31:0]   stall_cnt_o;
    logic          s_in_ready;
    logic          s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occupancy;
    logic [1:0]    s_bubble_cnt;
    logic [1:0]    s_stall_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W    (DW),
        .NOP_VALUE (NOP),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .bubble_cnt_o (bubble_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

`ifdef PIPE_STAGE_PERF_CNT_EN
    pipe_stage_reg #(
        .DATA_W    (DW),
        .NOP_VALUE (NOP),
        .CNT_W     (2)
    ) dut_small (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (s_in_ready),
        .in_data_i    (in_data_i),
        .out_valid_o  (s_out_valid),
        .out_ready_i  (out_ready_i),
        .out_data_o   (s_out_data),
        .occupancy_o  (s_occupancy),
        .bubble_cnt_o (s_bubble_cnt),
        .stall_cnt_o  (s_stall_cnt)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hDEAD;
        out_ready_i = 1'b0;
        repeat (3) step();
        tests_run++;
        if (out_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid_o);
        end
        tests_run++;
        if (out_data_o !== NOP) begin
            tests_failed++;
            $display("FAIL reset_out_data: got %h want %h", out_data_o, NOP);
        end
        tests_run++;
        if (in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready_o);
        end
        tests_run++;
        if (occupancy_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_occupancy: got %0d want 0", occupancy_o);
        end
        rst = 1'b1;
        step();
        tests_run++;
        if (out_data_o !== 32'hDEAD || out_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_first_entry: got valid=%b data=%h want valid=1 data=0000dead",
                     out_valid_o, out_data_o);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        tests_run++;
        if (out_valid_o !== 1'b0 || out_data_o !== NOP) begin
            tests_failed++;
            $display("FAIL reset_drain_bubble: got valid=%b data=%h want valid=0 data=%h",
                     out_valid_o, out_data_o, NOP);
        end
    endtask

    task automatic test_stream();
        out_ready_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = DW'(i);
            step();
            tests_run++;
            if (out_valid_o !== 1'b1 || out_data_o !== DW'(i)) begin
                tests_failed++;
                $display("FAIL stream_data_%0d: got valid=%b data=%h want valid=1 data=%h",
                         i, out_valid_o, out_data_o, DW'(i));
            end
            tests_run++;
            if (occupancy_o !== 2'd1) begin
                tests_failed++;
                $display("FAIL stream_occ_%0d: got %0d want 1", i, occupancy_o);
            end
        end
        in_valid_i = 1'b0;
        step();
        tests_run++;
        if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL stream_drain: got valid=%b occ=%0d want valid=0 occ=0",
                     out_valid_o, occupancy_o);
        end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hA;
        step();
        in_data_i = 32'hB;
        step();
        tests_run++;
        if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_full: got occ=%0d in_ready=%b want occ=2 in_ready=0",
                     occupancy_o, in_ready_o);
        end
        in_data_i = 32'hC;
        step();
        tests_run++;
        if (occupancy_o !== 2'd2 || out_data_o !== 32'hA || out_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_hold: got occ=%0d valid=%b data=%h want occ=2 valid=1 data=a",
                     occupancy_o, out_valid_o, out_data_o);
        end
        // A leaves at this edge; C is still refused because the stage was full.
        out_ready_i = 1'b1;
        step();
        tests_run++;
        if (out_data_o !== 32'hB || occupancy_o !== 2'd1) begin
            tests_failed++;
            $display("FAIL bp_second: got data=%h occ=%0d want data=b occ=1",
                     out_data_o, occupancy_o);
        end
        step();
        tests_run++;
        if (out_data_o !== 32'hC || occupancy_o !== 2'd1) begin
            tests_failed++;
            $display("FAIL bp_third: got data=%h occ=%0d want data=c occ=1",
                     out_data_o, occupancy_o);
        end
        in_valid_i = 1'b0;
        step();
        tests_run++;
        if (out_valid_o !== 1'b0 || out_data_o !== NOP) begin
            tests_failed++;
            $display("FAIL bp_no_dup: got valid=%b data=%h want valid=0 data=%h",
                     out_valid_o, out_data_o, NOP);
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h11;
        step();
        in_data_i = 32'h22;
        step();
        in_data_i = 32'h33;
        flush_i   = 1'b1;
        step();
        flush_i = 1'b0;
        tests_run++;
        if (out_valid_o !== 1'b0 || out_data_o !== NOP || occupancy_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL flush_full: got valid=%b data=%h occ=%0d want valid=0 data=%h occ=0",
                     out_valid_o, out_data_o, occupancy_o, NOP);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (out_valid_o !== 1'b0 || out_data_o === 32'h33) begin
                tests_failed++;
                $display("FAIL flush_leak_%0d: got valid=%b data=%h want valid=0",
                         i, out_valid_o, out_data_o);
            end
        end
        // Flush in state ONE while an entry is accepted: the new entry is discarded.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h44;
        step();
        in_data_i = 32'h55;
        flush_i   = 1'b1;
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        tests_run++;
        if (out_valid_o !== 1'b0 || out_data_o !== NOP || occupancy_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL flush_one: got valid=%b data=%h occ=%0d want valid=0 data=%h occ=0",
                     out_valid_o, out_data_o, occupancy_o, NOP);
        end
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h66;
        step();
        in_data_i = 32'h77;
        step();
        tests_run++;
        if (occupancy_o !== 2'd2) begin
            tests_failed++;
            $display("FAIL areset_prefill: got occ=%0d want 2", occupancy_o);
        end
        in_valid_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_valid_o !== 1'b0 || out_data_o !== NOP || occupancy_o !== 2'd0 ||
            in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_immediate: got valid=%b data=%h occ=%0d rdy=%b want 0 %h 0 1",
                     out_valid_o, out_data_o, occupancy_o, in_ready_o, NOP);
        end
        rst         = 1'b1;
        out_ready_i = 1'b1;
        step();
        tests_run++;
        if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL areset_after: got valid=%b occ=%0d want valid=0 occ=0",
                     out_valid_o, occupancy_o);
        end
    endtask

`ifdef PIPE_STAGE_PERF_CNT_EN
    task automatic test_perf_cnt();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        flush_i     = 1'b0;
        rst         = 1'b0;
        #1;
        rst = 1'b1;
        repeat (5) step();
        tests_run++;
        if (bubble_cnt_o !== 32'd5) begin
            tests_failed++;
            $display("FAIL perf_bubble: got %0d want 5", bubble_cnt_o);
        end
        tests_run++;
        if (s_bubble_cnt !== 2'd3) begin
            tests_failed++;
            $display("FAIL perf_bubble_sat: got %0d want 3", s_bubble_cnt);
        end
        // Two accepted entries fill the stage, then four refused cycles.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h88;
        repeat (2) step();
        repeat (4) step();
        tests_run++;
        if (stall_cnt_o !== 32'd4 || bubble_cnt_o !== 32'd5) begin
            tests_failed++;
            $display("FAIL perf_stall: got stall=%0d bubble=%0d want stall=4 bubble=5",
                     stall_cnt_o, bubble_cnt_o);
        end
        // Flush leaves counters untouched.
        flush_i    = 1'b1;
        in_valid_i = 1'b0;
        step();
        flush_i = 1'b0;
        tests_run++;
        if (stall_cnt_o !== 32'd4 || s_stall_cnt !== 2'd3) begin
            tests_failed++;
            $display("FAIL perf_flush_keep: got stall=%0d small=%0d want 4 3",
                     stall_cnt_o, s_stall_cnt);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef PIPE_STAGE_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
